// File: rtl/attn_seq.sv
// Attention-pass sequencer: emits the core instruction word that walks Q/K loading,
// kernel load, execution, output-FIFO drain into psum memory, then sfp accumulate/divide.
module attn_seq #(
  parameter int col = 8,
  parameter int len = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        ofifo_valid,
  output logic [16:0] inst,
  output logic        acc,
  output logic        div,
  output logic        busy,
  output logic        done
);

  typedef enum logic [3:0] {
    S_IDLE, S_QWR, S_KWR, S_KLOAD, S_KGAP, S_EXEC, S_DRAIN, S_ACC, S_DIV, S_FIN
  } state_t;

  localparam logic [4:0] LEN_C  = 5'(len);
  localparam logic [4:0] LEN_M1 = 5'(len - 1);
  localparam logic [4:0] COL_C  = 5'(col);
  localparam logic [4:0] COL_M1 = 5'(col - 1);

  state_t     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       wr_pend_q, wr_pend_d;
  logic [4:0] wa_q, wa_d;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      wr_pend_q <= 1'b0;
      wa_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_pend_q <= wr_pend_d;
      wa_q      <= wa_d;
    end
  end

  // NOTE: every output and next-state term gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_pend_d = wr_pend_q;
    wa_d      = wa_q;
    inst      = '0;
    acc       = 1'b0;
    div       = 1'b0;
    in_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_QWR;
          cnt_d   = '0;
        end
      end
      S_QWR, S_KWR: begin
        in_ready = 1'b1;
        if (in_valid) begin
          inst[15:12] = cnt_q[3:0];
          if (state_q == S_QWR) inst[4] = 1'b1;
          else                  inst[2] = 1'b1;
          cnt_d = cnt_q + 5'd1;
          if (state_q == S_QWR && cnt_q == LEN_M1) begin
            state_d = S_KWR;
            cnt_d   = '0;
          end else if (state_q == S_KWR && cnt_q == COL_M1) begin
            state_d = S_KLOAD;
            cnt_d   = '0;
          end
        end
      end
      S_KLOAD: begin
        // Extra trailing cycle covers the one-cycle kmem read latency.
        inst[6] = 1'b1;
        if (cnt_q < COL_C) begin
          inst[3]     = 1'b1;
          inst[15:12] = cnt_q[3:0];
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == COL_C) begin
          state_d = S_KGAP;
          cnt_d   = '0;
        end
      end
      S_KGAP: begin
        state_d = S_EXEC;
        cnt_d   = '0;
      end
      S_EXEC: begin
        inst[7] = 1'b1;
        if (cnt_q < LEN_C) begin
          inst[5]     = 1'b1;
          inst[15:12] = cnt_q[3:0];
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LEN_C) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end
      end
      S_DRAIN: begin
        // Each FIFO read is written to pmem one cycle later; rd and wr may share a cycle.
        wr_pend_d = 1'b0;
        if (ofifo_valid && cnt_q < LEN_C) begin
          inst[16]  = 1'b1;
          cnt_d     = cnt_q + 5'd1;
          wr_pend_d = 1'b1;
        end
        if (wr_pend_q) begin
          inst[0]    = 1'b1;
          inst[11:8] = wa_q[3:0];
          wa_d       = wa_q + 5'd1;
          if (wa_q == LEN_M1) begin
            state_d   = S_ACC;
            cnt_d     = '0;
            wr_pend_d = 1'b0;
            wa_d      = '0;
          end
        end
      end
      S_ACC, S_DIV: begin
        if (cnt_q < LEN_C) begin
          inst[1]    = 1'b1;
          inst[11:8] = cnt_q[3:0];
        end
        if (cnt_q != '0) begin
          if (state_q == S_ACC) acc = 1'b1;
          else                  div = 1'b1;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == LEN_C) begin
          state_d = (state_q == S_ACC) ? S_DIV : S_FIN;
          cnt_d   = '0;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_FIN);

endmodule

// File: tb/tb_attn_seq.sv
// Cycle-exact directed bench for attn_seq: a vector table for reset/start/QWR
// handshaking, then hand-sequenced full passes covering drain stalls, KLOAD start and mid-pass reset.
module tb_attn_seq;

  localparam int COL = 8;
  localparam int LEN = 16;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, ofifo_valid;
  logic        in_ready, acc, div, busy, done;
  logic [16:0] inst;

  int n_vec  = 0;
  int n_miss = 0;

  attn_seq #(.col(COL), .len(LEN)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .ofifo_valid(ofifo_valid), .inst(inst),
    .acc(acc), .div(div), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, iv, ov;
    logic [16:0] e_inst;
    logic        e_acc, e_div, e_rdy, e_busy, e_done;
  } vec_t;

  vec_t vecs [11];

  // Drive inputs on the falling edge, check the decoded outputs just after.
  task automatic step(input logic r, s, iv, ov, input logic [16:0] ei,
                      input logic ea, ed, er, eb, edn, input string nm);
    @(negedge clk);
    reset = r; start = s; in_valid = iv; ofifo_valid = ov;
    #1;
    n_vec++;
    if ({inst, acc, div, in_ready, busy, done} !== {ei, ea, ed, er, eb, edn}) begin
      n_miss++;
      $display("FAIL %s @%0t: got inst=%h acc=%b div=%b rdy=%b busy=%b done=%b, want inst=%h acc=%b div=%b rdy=%b busy=%b done=%b",
               nm, $time, inst, acc, div, in_ready, busy, done, ei, ea, ed, er, eb, edn);
    end
  endtask

  function automatic logic [16:0] qk_addr(input int a);
    return 17'(a % 16) << 12;
  endfunction

  function automatic logic [16:0] p_addr(input int a);
    return 17'(a % 16) << 8;
  endfunction

  task automatic run_pass(input int gap, input bit kstart, input int abort_at);
    step(0, 1, 1, 1, '0, 0, 0, 0, 0, 0, "idle_start");
    for (int i = 0; i < LEN; i++)
      step(0, 0, 1, 1, qk_addr(i) | 17'h00010, 0, 0, 1, 1, 0, "qwr");
    for (int i = 0; i < COL; i++)
      step(0, 0, 1, 1, qk_addr(i) | 17'h00004, 0, 0, 1, 1, 0, "kwr");
    for (int i = 0; i <= COL; i++)
      step(0, kstart && i == 3, 1, 1,
           17'h00040 | ((i < COL) ? (qk_addr(i) | 17'h00008) : 17'h0),
           0, 0, 0, 1, 0, "kload");
    step(0, 0, 1, 1, '0, 0, 0, 0, 1, 0, "kgap");
    for (int i = 0; i <= LEN; i++) begin
      logic [16:0] e;
      e = 17'h00080 | ((i < LEN) ? (qk_addr(i) | 17'h00020) : 17'h0);
      if (i == abort_at) begin
        step(1, 1, 1, 1, e, 0, 0, 0, 1, 0, "exec_reset");
        step(0, 0, 1, 1, '0, 0, 0, 0, 0, 0, "after_reset");
        step(0, 0, 1, 1, '0, 0, 0, 0, 0, 0, "after_reset_idle");
        return;
      end
      step(0, 0, 1, 1, e, 0, 0, 0, 1, 0, "exec");
    end
    for (int g = 0; g < gap; g++)
      step(0, 0, 1, 0, '0, 0, 0, 0, 1, 0, "drain_gap");
    for (int j = 0; j <= LEN; j++)
      step(0, 0, 1, 1,
           ((j < LEN) ? 17'h10000 : 17'h0) | ((j >= 1) ? (p_addr(j - 1) | 17'h00001) : 17'h0),
           0, 0, 0, 1, 0, "drain");
    for (int i = 0; i <= LEN; i++)
      step(0, 0, 1, 1, (i < LEN) ? (p_addr(i) | 17'h00002) : 17'h0,
           i >= 1, 0, 0, 1, 0, "acc");
    for (int i = 0; i <= LEN; i++)
      step(0, 0, 1, 1, (i < LEN) ? (p_addr(i) | 17'h00002) : 17'h0,
           0, i >= 1, 0, 1, 0, "div");
    step(0, 0, 1, 1, '0, 0, 0, 0, 1, 1, "fin");
    for (int i = 0; i < 3; i++)
      step(0, 0, 1, 1, '0, 0, 0, 0, 0, 0, "post_idle");
  endtask

  initial begin
    //            rst st iv ov  inst      acc div rdy busy done
    vecs[0]  = '{0, 0, 0, 0, 17'h00000, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 0, 0, 17'h00000, 0, 0, 0, 0, 0};
    vecs[2]  = '{0, 0, 0, 0, 17'h00000, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 17'h00000, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 0, 1, 0, 17'h00010, 0, 0, 1, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 17'h00000, 0, 0, 1, 1, 0};
    vecs[6]  = '{0, 0, 1, 0, 17'h01010, 0, 0, 1, 1, 0};
    vecs[7]  = '{0, 0, 0, 0, 17'h00000, 0, 0, 1, 1, 0};
    vecs[8]  = '{0, 0, 1, 0, 17'h02010, 0, 0, 1, 1, 0};
    vecs[9]  = '{1, 1, 0, 0, 17'h00000, 0, 0, 1, 1, 0};
    vecs[10] = '{0, 0, 0, 0, 17'h00000, 0, 0, 0, 0, 0};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; ofifo_valid = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < 11; k++)
      step(vecs[k].rst, vecs[k].st, vecs[k].iv, vecs[k].ov, vecs[k].e_inst,
           vecs[k].e_acc, vecs[k].e_div, vecs[k].e_rdy, vecs[k].e_busy,
           vecs[k].e_done, $sformatf("vec%0d", k));

    run_pass(0, 1'b1, -1);
    run_pass(5, 1'b0, -1);
    run_pass(0, 1'b0, 7);
    run_pass(0, 1'b0, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
